// File: rtl/openofdm_rx_side_ch_sched_if.sv
// Record stream for the side-channel scheduler: one 32-bit word per beat, out_last marks
// the final word of a packet record.
interface openofdm_rx_side_ch_sched_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/openofdm_rx_side_ch_sched.sv
// Per-packet capture of CSI and equalizer samples, emitted as one framed record
// (3 header words, CSI section, equalizer section) once FCS is reported.
module openofdm_rx_side_ch_sched #(
    parameter int unsigned CSI_AW = 6,
    parameter int unsigned EQ_AW  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [EQ_AW:0]       eq_words_max,
    input  logic                 long_preamble_detected,
    input  logic [31:0]          phase_offset_taken,
    input  logic [31:0]          csi,
    input  logic                 csi_valid,
    input  logic [31:0]          equalizer,
    input  logic                 equalizer_valid,
    input  logic                 pkt_header_valid_strobe,
    input  logic                 pkt_header_valid,
    input  logic [7:0]           pkt_rate,
    input  logic [15:0]          pkt_len,
    input  logic                 fcs_out_strobe,
    input  logic                 fcs_ok,
    openofdm_rx_side_ch_sched_if.master out_if,
    output logic                 busy,
    output logic [15:0]          pkt_count,
    output logic [15:0]          drop_count
);

    localparam int unsigned CsiDepth = 1 << CSI_AW;
    localparam int unsigned EqDepth  = 1 << EQ_AW;
    localparam int unsigned PW       = ((EQ_AW > CSI_AW) ? EQ_AW : CSI_AW) + 1;

    typedef logic [CSI_AW:0] csi_cnt_t;
    typedef logic [EQ_AW:0]  eq_cnt_t;
    typedef logic [PW-1:0]   ptr_t;

    localparam csi_cnt_t CsiFull = csi_cnt_t'(CsiDepth);
    localparam eq_cnt_t  EqFull  = eq_cnt_t'(EqDepth);

    typedef enum logic [2:0] {StIdle, StCapture, StEmitHdr, StEmitCsi, StEmitEq} state_e;

    state_e      state_q, state_d;
    csi_cnt_t    csi_cnt_q, csi_cnt_d;
    eq_cnt_t     eq_cnt_q, eq_cnt_d;
    logic        csi_ovf_q, csi_ovf_d;
    logic        eq_trunc_q, eq_trunc_d;
    logic        fcs_ok_q, fcs_ok_d;
    logic [7:0]  rate_q, rate_d;
    logic [15:0] len_q, len_d;
    logic [31:0] phase_q, phase_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [15:0] pkt_count_q, drop_count_q;

    logic        csi_we, eq_we, drop_inc, pkt_inc, start_clr, to_csi, to_eq;
    eq_cnt_t     eq_lim;
    ptr_t        csi_n, eq_n, ptr_nx;
    logic [31:0] w2;

    logic [31:0] csi_mem [CsiDepth];
    logic [31:0] eq_mem  [EqDepth];

    assign eq_lim = (eq_words_max > EqFull) ? EqFull : eq_words_max;
    assign csi_n  = ptr_t'(csi_cnt_q);
    assign eq_n   = ptr_t'(eq_cnt_q);
    assign ptr_nx = rd_ptr_q + ptr_t'(1);
    assign w2     = {16'(csi_cnt_q), 16'(eq_cnt_q)};

    always_ff @(posedge clock) begin
        if (csi_we) csi_mem[csi_cnt_q[CSI_AW-1:0]] <= csi;
        if (eq_we)  eq_mem[eq_cnt_q[EQ_AW-1:0]]    <= equalizer;
    end

    always_comb begin
        state_d     = state_q;
        csi_cnt_d   = csi_cnt_q;
        eq_cnt_d    = eq_cnt_q;
        csi_ovf_d   = csi_ovf_q;
        eq_trunc_d  = eq_trunc_q;
        fcs_ok_d    = fcs_ok_q;
        rate_d      = rate_q;
        len_d       = len_q;
        phase_d     = phase_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        csi_we      = 1'b0;
        eq_we       = 1'b0;
        drop_inc    = 1'b0;
        pkt_inc     = 1'b0;
        start_clr   = 1'b0;
        to_csi      = 1'b0;
        to_eq       = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable && long_preamble_detected) begin
                    state_d   = StCapture;
                    start_clr = 1'b1;
                end
            end
            StCapture: begin
                if (csi_valid) begin
                    if (csi_cnt_q < CsiFull) begin
                        csi_we    = 1'b1;
                        csi_cnt_d = csi_cnt_q + csi_cnt_t'(1);
                    end else begin
                        csi_ovf_d = 1'b1;
                    end
                end
                if (equalizer_valid) begin
                    if (eq_cnt_q < eq_lim) begin
                        eq_we    = 1'b1;
                        eq_cnt_d = eq_cnt_q + eq_cnt_t'(1);
                    end else begin
                        eq_trunc_d = 1'b1;
                    end
                end
                if (pkt_header_valid_strobe && pkt_header_valid) begin
                    rate_d = pkt_rate;
                    len_d  = pkt_len;
                end
                // Priority: header-invalid abort, then FCS, then restart.
                if (pkt_header_valid_strobe && !pkt_header_valid) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end else if (fcs_out_strobe) begin
                    fcs_ok_d    = fcs_ok;
                    state_d     = StEmitHdr;
                    rd_ptr_d    = '0;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    out_data_d  = {4'hC, fcs_ok, csi_ovf_d, eq_trunc_d, 1'b0, rate_d, len_d};
                    drop_inc    = long_preamble_detected;
                end else if (long_preamble_detected) begin
                    drop_inc  = 1'b1;
                    start_clr = 1'b1;
                end
            end
            StEmitHdr, StEmitCsi, StEmitEq: begin
                drop_inc = long_preamble_detected;
                if (out_valid_q && out_if.out_ready) begin
                    if (out_last_q) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        pkt_inc     = 1'b1;
                    end else begin
                        case (state_q)
                            StEmitHdr: begin
                                if (rd_ptr_q != ptr_t'(2)) begin
                                    rd_ptr_d   = ptr_nx;
                                    out_data_d = (rd_ptr_q == '0) ? phase_q : w2;
                                    out_last_d = (rd_ptr_q != '0) && (csi_n == '0) && (eq_n == '0);
                                end else if (csi_n != '0) begin
                                    to_csi = 1'b1;
                                end else begin
                                    to_eq = 1'b1;
                                end
                            end
                            StEmitCsi: begin
                                if (ptr_nx < csi_n) begin
                                    rd_ptr_d   = ptr_nx;
                                    out_data_d = csi_mem[ptr_nx[CSI_AW-1:0]];
                                    out_last_d = (ptr_nx == csi_n - ptr_t'(1)) && (eq_n == '0);
                                end else begin
                                    to_eq = 1'b1;
                                end
                            end
                            default: begin
                                rd_ptr_d   = ptr_nx;
                                out_data_d = eq_mem[ptr_nx[EQ_AW-1:0]];
                                out_last_d = (ptr_nx == eq_n - ptr_t'(1));
                            end
                        endcase
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Sections are entered at their first word so empty ones cost no cycle.
        if (to_csi) begin
            state_d    = StEmitCsi;
            rd_ptr_d   = '0;
            out_data_d = csi_mem[0];
            out_last_d = (csi_n == ptr_t'(1)) && (eq_n == '0);
        end
        if (to_eq) begin
            state_d    = StEmitEq;
            rd_ptr_d   = '0;
            out_data_d = eq_mem[0];
            out_last_d = (eq_n == ptr_t'(1));
        end

        if (start_clr) begin
            phase_d    = phase_offset_taken;
            csi_cnt_d  = '0;
            eq_cnt_d   = '0;
            csi_ovf_d  = 1'b0;
            eq_trunc_d = 1'b0;
            fcs_ok_d   = 1'b0;
            rate_d     = '0;
            len_d      = '0;
            csi_we     = 1'b0;
            eq_we      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            csi_cnt_q    <= '0;
            eq_cnt_q     <= '0;
            csi_ovf_q    <= 1'b0;
            eq_trunc_q   <= 1'b0;
            fcs_ok_q     <= 1'b0;
            rate_q       <= '0;
            len_q        <= '0;
            phase_q      <= '0;
            rd_ptr_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q     <= state_d;
            csi_cnt_q   <= csi_cnt_d;
            eq_cnt_q    <= eq_cnt_d;
            csi_ovf_q   <= csi_ovf_d;
            eq_trunc_q  <= eq_trunc_d;
            fcs_ok_q    <= fcs_ok_d;
            rate_q      <= rate_d;
            len_q       <= len_d;
            phase_q     <= phase_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            if (pkt_inc && (pkt_count_q != 16'hFFFF)) pkt_count_q <= pkt_count_q + 16'd1;
            if (drop_inc && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = (state_q != StIdle);
    assign pkt_count        = pkt_count_q;
    assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_openofdm_rx_side_ch_sched.sv
// Randomised bench: a queue-based packet model predicts each record, a monitor checks beats.
module tb_openofdm_rx_side_ch_sched;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [8:0]  eq_words_max = '0;
    logic        long_preamble_detected = 1'b0;
    logic [31:0] phase_offset_taken = '0;
    logic [31:0] csi = '0;
    logic        csi_valid = 1'b0;
    logic [31:0] equalizer = '0;
    logic        equalizer_valid = 1'b0;
    logic        pkt_header_valid_strobe = 1'b0;
    logic        pkt_header_valid = 1'b0;
    logic [7:0]  pkt_rate = '0;
    logic [15:0] pkt_len = '0;
    logic        fcs_out_strobe = 1'b0;
    logic        fcs_ok = 1'b0;
    logic        busy;
    logic [15:0] pkt_count, drop_count;

    openofdm_rx_side_ch_sched_if out_if ();

    openofdm_rx_side_ch_sched #(.CSI_AW(6), .EQ_AW(8)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .enable                  (enable),
        .eq_words_max            (eq_words_max),
        .long_preamble_detected  (long_preamble_detected),
        .phase_offset_taken      (phase_offset_taken),
        .csi                     (csi),
        .csi_valid               (csi_valid),
        .equalizer               (equalizer),
        .equalizer_valid         (equalizer_valid),
        .pkt_header_valid_strobe (pkt_header_valid_strobe),
        .pkt_header_valid        (pkt_header_valid),
        .pkt_rate                (pkt_rate),
        .pkt_len                 (pkt_len),
        .fcs_out_strobe          (fcs_out_strobe),
        .fcs_ok                  (fcs_ok),
        .out_if                  (out_if),
        .busy                    (busy),
        .pkt_count               (pkt_count),
        .drop_count              (drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] rec_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          beats = 0;
    int          ready_mode = 0;
    int          exp_pkt = 0;
    int          exp_drop = 0;
    bit          stall = 0;
    bit          xfer_nl = 0;
    logic [31:0] held_d;
    logic        held_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        out_if.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       out_if.out_ready = 1'b1;
                1:       out_if.out_ready = !out_if.out_ready;
                default: out_if.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a transfer is valid & ready as seen half a cycle before the active edge.
    always @(negedge clock) begin
        beat_t e;
        if (reset) begin
            stall   = 0;
            xfer_nl = 0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(out_if.out_valid), 32'd1);
                check("hold_data", out_if.out_data, held_d);
                check("hold_last", 32'(out_if.out_last), 32'(held_l));
            end
            if (xfer_nl) check("no_gap", 32'(out_if.out_valid), 32'd1);
            if (out_if.out_valid && out_if.out_ready) begin
                beats++;
                rec_q.push_back(out_if.out_data);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h, expected no beat", out_if.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_if.out_data, e.d);
                    check("beat_last", 32'(out_if.out_last), 32'(e.l));
                end
            end
            stall   = out_if.out_valid && !out_if.out_ready;
            held_d  = out_if.out_data;
            held_l  = out_if.out_last;
            xfer_nl = out_if.out_valid && out_if.out_ready && !out_if.out_last;
        end
    end

    // Drives one packet up to and including the FCS strobe; the model follows the rules
    // directly with sample queues and pushes the whole predicted record.
    task automatic capture_packet(input int n_csi, input int n_eq, input int eq_max, input bit hdr,
                                  input logic [7:0] rate, input logic [15:0] len, input bit fok,
                                  input bit restart, input bit fcs_pulse);
        logic [31:0] cq[$];
        logic [31:0] eqq[$];
        logic [31:0] words[$];
        bit          ovf = 0;
        bit          trunc = 0;
        logic [7:0]  m_rate = '0;
        logic [15:0] m_len = '0;
        logic [31:0] ph;
        beat_t       b;
        int          lim = (eq_max > 256) ? 256 : eq_max;
        int          rc = n_csi;
        int          re = n_eq;
        eq_words_max = 9'(eq_max);
        ph = $urandom;
        phase_offset_taken = ph;
        long_preamble_detected = 1'b1;
        csi_valid = 1'b1;
        csi = 32'hDEAD_0000;
        tick();
        long_preamble_detected = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        for (int c = 0; rc > 0 || re > 0 || c <= 2; c++) begin
            csi_valid = 1'b0;
            equalizer_valid = 1'b0;
            pkt_header_valid_strobe = 1'b0;
            if (restart && c == 1) begin
                long_preamble_detected = 1'b1;
                ph = $urandom;
                phase_offset_taken = ph;
                cq.delete();
                eqq.delete();
                ovf = 0;
                trunc = 0;
                m_rate = '0;
                m_len = '0;
                exp_drop++;
            end else begin
                if (rc > 0 && $urandom_range(0, 3) != 0) begin
                    csi = $urandom;
                    csi_valid = 1'b1;
                    rc--;
                    if (cq.size() < 64) cq.push_back(csi);
                    else ovf = 1;
                end
                if (re > 0 && $urandom_range(0, 3) != 0) begin
                    equalizer = $urandom;
                    equalizer_valid = 1'b1;
                    re--;
                    if (eqq.size() < lim) eqq.push_back(equalizer);
                    else trunc = 1;
                end
                if (hdr && c == 2) begin
                    pkt_header_valid_strobe = 1'b1;
                    pkt_header_valid = 1'b1;
                    pkt_rate = rate;
                    pkt_len = len;
                    m_rate = rate;
                    m_len = len;
                end
            end
            tick();
            long_preamble_detected = 1'b0;
        end
        csi_valid = 1'b0;
        equalizer_valid = 1'b0;
        pkt_header_valid_strobe = 1'b0;
        fcs_out_strobe = 1'b1;
        fcs_ok = fok;
        if (fcs_pulse) begin
            long_preamble_detected = 1'b1;
            exp_drop++;
        end
        words.push_back({4'hC, fok, ovf, trunc, 1'b0, m_rate, m_len});
        words.push_back(ph);
        words.push_back({16'(cq.size()), 16'(eqq.size())});
        foreach (cq[i]) words.push_back(cq[i]);
        foreach (eqq[i]) words.push_back(eqq[i]);
        foreach (words[i]) begin
            b.d = words[i];
            b.l = (i == words.size() - 1);
            exp_q.push_back(b);
        end
        exp_pkt++;
        tick();
        fcs_out_strobe = 1'b0;
        long_preamble_detected = 1'b0;
        check("emit_latency", 32'(out_if.out_valid), 32'd1);
    endtask

    task automatic finish_record(input bit emit_pulse);
        int  base = beats;
        bit  pulsed = 0;
        int  i;
        for (i = 0; i < 4000 && (exp_q.size() != 0 || busy); i++) begin
            long_preamble_detected = 1'b0;
            if (emit_pulse && !pulsed && beats >= base + 5) begin
                long_preamble_detected = 1'b1;
                pulsed = 1;
                exp_drop++;
            end
            tick();
        end
        long_preamble_detected = 1'b0;
        check("record_done", 32'(i < 4000), 32'd1);
        check("pkt_count", 32'(pkt_count), 32'(exp_pkt));
        check("drop_count", 32'(drop_count), 32'(exp_drop));
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_valid", 32'(out_if.out_valid), 32'd0);
        check("rst_last", 32'(out_if.out_last), 32'd0);
        check("rst_data", out_if.out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt", 32'(pkt_count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        enable = 1'b1;

        // Nominal packet.
        rec_q.delete();
        capture_packet(52, 48, 48, 1, 8'h0B, 16'd100, 1, 0, 0);
        finish_record(0);
        check("nom_w0", rec_q[0], 32'hC80B0064);
        check("nom_w2", rec_q[2], 32'h00340030);
        check("nom_beats", 32'(rec_q.size()), 32'd103);

        // Overflow and truncation.
        rec_q.delete();
        capture_packet(70, 300, 300, 1, 8'h0B, 16'd100, 1, 0, 0);
        finish_record(0);
        check("ovf_w0", rec_q[0], 32'hCE0B0064);
        check("ovf_w2", rec_q[2], 32'h00400100);
        check("ovf_beats", 32'(rec_q.size()), 32'd323);

        // Header invalid aborts the capture.
        long_preamble_detected = 1'b1;
        tick();
        long_preamble_detected = 1'b0;
        csi_valid = 1'b1;
        csi = 32'h1234_5678;
        tick();
        csi_valid = 1'b0;
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid = 1'b0;
        exp_drop++;
        tick();
        pkt_header_valid_strobe = 1'b0;
        check("hinv_busy", 32'(busy), 32'd0);
        check("hinv_drop", 32'(drop_count), 32'(exp_drop));
        repeat (3) tick();
        check("hinv_valid", 32'(out_if.out_valid), 32'd0);

        // Backpressure with alternating ready.
        ready_mode = 1;
        rec_q.delete();
        capture_packet(52, 48, 48, 1, 8'h0B, 16'd100, 1, 0, 0);
        finish_record(0);
        check("bp_w0", rec_q[0], 32'hC80B0064);
        check("bp_beats", 32'(rec_q.size()), 32'd103);
        ready_mode = 0;

        // Overlap: restart in capture and a pulse during the CSI section.
        capture_packet(52, 48, 48, 1, 8'h21, 16'd77, 0, 1, 0);
        finish_record(1);
        // FCS and start pulse in the same cycle.
        capture_packet(10, 10, 48, 1, 8'h05, 16'd9, 1, 0, 1);
        finish_record(0);

        // Empty record: last beat is w2, no header seen.
        rec_q.delete();
        capture_packet(0, 0, 48, 0, 8'h00, 16'd0, 0, 0, 0);
        finish_record(0);
        check("empty_w0", rec_q[0], 32'hC0000000);
        check("empty_beats", 32'(rec_q.size()), 32'd3);

        for (int p = 0; p < 20; p++) begin
            ready_mode = $urandom_range(0, 2);
            capture_packet($urandom_range(0, 80), $urandom_range(0, 300), $urandom_range(0, 511),
                           1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
            finish_record(1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a record, then a start pulse while disabled.
        ready_mode = 0;
        begin
            int base;
            int k;
            capture_packet(30, 30, 64, 1, 8'h0D, 16'd20, 1, 0, 0);
            base = beats;
            for (k = 0; k < 200 && beats < base + 10; k++) tick();
            check("mid_reached", 32'(k < 200), 32'd1);
        end
        reset = 1'b1;
        tick();
        exp_q.delete();
        exp_pkt = 0;
        exp_drop = 0;
        check("mid_rst_valid", 32'(out_if.out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pkt", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        enable = 1'b0;
        tick();
        long_preamble_detected = 1'b1;
        tick();
        long_preamble_detected = 1'b0;
        check("dis_busy", 32'(busy), 32'd0);
        tick();
        check("dis_busy2", 32'(busy), 32'd0);
        check("dis_drop", 32'(drop_count), 32'(exp_drop));
        check("dis_valid", 32'(out_if.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end
endmodule
